// File: rtl/media_sequencer.sv
// media_sequencer
//   Steps the accumulate/divide datapath through one mean computation over
//   2^log2n operands. Operands come from an upstream source over a
//   valid/ready handshake. Each accepted operand is registered on data_out
//   and followed by a mandatory GAP cycle, so the decoder always sees the
//   value for at least two cycles. One 3-bit instruction is emitted per
//   step, with a valid flag.
//
//   Instruction codes: clrld=000 addld=001 add=010 div2=011 disp=100.
//   The idle code 111 is never decoded downstream. add is never issued.
//
// Ports
//   clk, rst     clock (rising edge); asynchronous active-high reset
//   start        begin a run (sampled only in IDLE)
//   log2n        log2 of the operand count; captured when start is taken
//   op_valid     upstream operand available
//   op_data      upstream operand
//   op_ready     operand is accepted this cycle (FIRST/ACCUM only)
//   data_out     last accepted operand; held until the next handshake
//   instr        registered instruction code (111 when no step)
//   instr_valid  instr is a real step this cycle
//   busy         a run is in progress
//   done         one-cycle pulse at the end of a run
module media_sequencer #(
  parameter int W  = 8,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] log2n,
  input  logic          op_valid,
  input  logic [W-1:0]  op_data,
  output logic          op_ready,
  output logic [W-1:0]  data_out,
  output logic [2:0]    instr,
  output logic          instr_valid,
  output logic          busy,
  output logic          done
);

  // The largest log2n is 2^LW-1, so the count of remaining addld steps
  // (2^log2n - 1) fits in 2^LW-1 bits.
  localparam int RW = (1 << LW) - 1;

  localparam logic [2:0] I_CLRLD = 3'b000;
  localparam logic [2:0] I_ADDLD = 3'b001;
  localparam logic [2:0] I_DIV2  = 3'b011;
  localparam logic [2:0] I_DISP  = 3'b100;
  localparam logic [2:0] I_IDLE  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_ACCUM, S_GAP, S_DIV, S_DISP, S_FIN
  } state_t;

  state_t        state;
  logic [RW-1:0] remaining;
  logic [LW-1:0] divcnt;
  logic [RW:0]   opcount;
  logic          hs;

  // 2^log2n computed one bit wider so that 2^log2n - 1 does not overflow.
  assign opcount = {{RW{1'b0}}, 1'b1} << log2n;

  // Ready is decoded from the state alone, so it is low during reset and
  // low in every state that is not waiting for an operand.
  assign op_ready = (state == S_FIRST) || (state == S_ACCUM);
  assign hs       = op_valid & op_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      divcnt      <= '0;
      data_out    <= '0;
      instr       <= I_IDLE;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Step outputs fall back to idle unless this edge issues a step.
      instr       <= I_IDLE;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= opcount[RW-1:0] - RW'(1);
            divcnt    <= log2n;
            busy      <= 1'b1;
            state     <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (hs) begin
            data_out    <= op_data;
            instr       <= I_CLRLD;
            instr_valid <= 1'b1;
            state       <= S_GAP;
          end
        end
        S_ACCUM: begin
          if (hs) begin
            data_out    <= op_data;
            instr       <= I_ADDLD;
            instr_valid <= 1'b1;
            remaining   <= remaining - RW'(1);
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (remaining != '0)   state <= S_ACCUM;
          else if (divcnt != '0) state <= S_DIV;
          else                   state <= S_DISP;
        end
        S_DIV: begin
          // GAP only enters DIV with divcnt nonzero, so there are exactly
          // log2n div2 steps.
          instr       <= I_DIV2;
          instr_valid <= 1'b1;
          divcnt      <= divcnt - LW'(1);
          if (divcnt == LW'(1)) state <= S_DISP;
        end
        S_DISP: begin
          // busy drops and done rises together as FIN is entered.
          instr       <= I_DISP;
          instr_valid <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_media_sequencer.sv
module tb_media_sequencer;
  localparam int W  = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] log2n;
  logic          op_valid;
  logic [W-1:0]  op_data;
  logic          op_ready;
  logic [W-1:0]  data_out;
  logic [2:0]    instr;
  logic          instr_valid;
  logic          busy;
  logic          done;

  media_sequencer #(.W(W), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .log2n(log2n),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .data_out(data_out), .instr(instr), .instr_valid(instr_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observation model: what the decoder saw, per run.
  bit         mon_en = 1'b0;
  bit         prev_hs = 1'b0;
  logic [7:0] last_data = '0;
  int         hs_cnt = 0;
  int         done_cnt = 0;
  logic [2:0] steps[$];

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("data_out_hold", 32'(data_out), 32'(last_data));
      if (!instr_valid) chk("instr_idle", 32'(instr), 32'h7);
      else steps.push_back(instr);
      if (prev_hs) chk("gap_ready", 32'(op_ready), 32'h0);
      if (done) done_cnt++;
      prev_hs = op_valid && op_ready;
      if (prev_hs) begin
        last_data = op_data;
        hs_cnt++;
      end
    end
  end

  // One run: start with log2n=n, feed operands with random availability.
  // noisy holds start high (with random log2n) for the whole run, covering
  // start during busy and during FIN. stall5 withholds the second operand.
  task automatic do_run(input int n, input bit noisy, input bit stall5, input bit full_rate);
    logic [2:0] exp_q[$];
    int cyc, stall;
    exp_q.push_back(3'b000);
    repeat ((1 << n) - 1) exp_q.push_back(3'b001);
    repeat (n) exp_q.push_back(3'b011);
    exp_q.push_back(3'b100);
    steps.delete();
    hs_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; log2n = LW'(n);
    @(posedge clk); #1;
    start = noisy;
    cyc = 0; stall = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      op_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
      op_data  = 8'($urandom);
      if (stall5 && hs_cnt == 1 && stall < 5) begin
        op_valid = 1'b0;
        stall++;
      end
      if (noisy) log2n = LW'($urandom);
      if (cyc == 0) begin
        @(negedge clk);
        chk("busy_run", 32'(busy), 32'h1);
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    if (done_cnt == 0) chk("run_timeout", 32'h0, 32'h1);
    start = 1'b0; op_valid = 1'b0;
    // Two idle cycles: no new run may begin from the ignored start.
    repeat (2) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_ready", 32'(op_ready), 32'h0);
      @(posedge clk); #1;
    end
    chk("step_count", 32'(steps.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < steps.size(); i++)
      chk("step_code", 32'(steps[i]), 32'(exp_q[i]));
    chk("handshakes", 32'(hs_cnt), 32'(1 << n));
    chk("done_pulses", 32'(done_cnt), 32'h1);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; start = 1'b0; log2n = '0; op_valid = 1'b0; op_data = '0;
    #2;
    chk("rst_instr", 32'(instr), 32'h7);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_ready", 32'(op_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;

    // Single operand 0x2A: clrld then disp.
    steps.delete(); hs_cnt = 0; done_cnt = 0;
    @(posedge clk); #1; start = 1'b1; log2n = 2'd0;
    @(posedge clk); #1; start = 1'b0; op_valid = 1'b1; op_data = 8'h2A;
    cyc = 0;
    while (done_cnt == 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    op_valid = 1'b0;
    @(negedge clk);
    chk("n0_data", 32'(data_out), 32'h2A);
    chk("n0_steps", 32'(steps.size()), 32'h2);
    if (steps.size() == 2) begin
      chk("n0_clrld", 32'(steps[0]), 32'h0);
      chk("n0_disp", 32'(steps[1]), 32'h4);
    end
    chk("n0_hs", 32'(hs_cnt), 32'h1);
    chk("n0_done", 32'(done_cnt), 32'h1);

    do_run(2, 1'b0, 1'b0, 1'b1);   // back-to-back operands
    do_run(1, 1'b0, 1'b1, 1'b1);   // stalled second operand
    do_run(3, 1'b0, 1'b0, 1'b1);   // eight operands, three div2
    do_run(2, 1'b1, 1'b0, 1'b0);   // start held during busy and FIN
    for (int k = 0; k < 8; k++)
      do_run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Reset in the middle of the divide phase.
    steps.delete();
    @(posedge clk); #1; start = 1'b1; log2n = 2'd2;
    @(posedge clk); #1; start = 1'b0; op_valid = 1'b1; op_data = 8'h55;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      seen = instr_valid && instr == 3'b011;
      cyc++;
    end
    chk("div_reached", 32'(seen), 32'h1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_instr", 32'(instr), 32'h7);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(op_ready), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    op_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    last_data = '0; prev_hs = 1'b0;
    mon_en = 1'b1;
    do_run(2, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
